// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the single-port data memory.
// Each access takes IDLE/DONE (accept) -> ACCESS (drive memory) -> DONE (respond).
module dmem_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [WIDTH-1:0]  addr0,
  input  logic [WIDTH-1:0]  addr1,
  input  logic [WIDTH-1:0]  wdata0,
  input  logic [WIDTH-1:0]  wdata1,
  input  logic [1:0]        size0,
  input  logic [1:0]        size1,
  input  logic              uns0,
  input  logic              uns1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [WIDTH-1:0]  rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_b,
  output logic              mem_h,
  output logic              mem_w,
  output logic              mem_uns,
  input  logic [WIDTH-1:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state, state_nxt;

  logic              prio;
  logic              owner;
  logic              l_we, l_uns, l_err;
  logic [1:0]        l_size;
  logic [ADDR_W-1:0] l_addr;
  logic [WIDTH-1:0]  l_wdata;
  logic [ADDR_W-1:0] addr_hold;
  logic [WIDTH-1:0]  wdata_hold;

  logic              can_accept, accept, sel;
  logic              sel_we, sel_uns, sel_err;
  logic [1:0]        sel_size;
  logic [WIDTH-1:0]  sel_addr, sel_wdata;
  logic              drive, live;

  // Out of range, reserved size, or misaligned half/word
  function automatic logic bad_access(input logic [WIDTH-1:0] a, input logic [1:0] s);
    bad_access = (a[WIDTH-1:ADDR_W] != '0) || (s == 2'b11) ||
                 ((s == 2'b01) && a[0]) || ((s == 2'b10) && (a[1:0] != 2'b00));
  endfunction

  always_comb begin
    state_nxt  = state;
    can_accept = !rst && ((state == IDLE) || (state == DONE));
    gnt0       = can_accept && req0 && (!req1 || !prio);
    gnt1       = can_accept && req1 && (!req0 || prio);
    accept     = gnt0 || gnt1;
    sel        = gnt1;
    sel_we     = sel ? we1    : we0;
    sel_uns    = sel ? uns1   : uns0;
    sel_size   = sel ? size1  : size0;
    sel_addr   = sel ? addr1  : addr0;
    sel_wdata  = sel ? wdata1 : wdata0;
    sel_err    = bad_access(sel_addr, sel_size);
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = accept ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are gated by rst so a reset mid-ACCESS drops the access at once
  always_comb begin
    drive     = (state == ACCESS) && !l_err;
    live      = drive && !rst;
    mem_we    = live && l_we;
    mem_re    = live && !l_we;
    mem_b     = live && (l_size == 2'b00);
    mem_h     = live && (l_size == 2'b01);
    mem_w     = live && (l_size == 2'b10);
    mem_uns   = live && l_uns;
    mem_addr  = drive ? l_addr  : addr_hold;
    mem_wdata = drive ? l_wdata : wdata_hold;
    done0     = !rst && (state == DONE) && !owner;
    done1     = !rst && (state == DONE) && owner;
    err0      = done0 && l_err;
    err1      = done1 && l_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      owner <= 1'b0;
      l_err <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        prio    <= ~sel;
        owner   <= sel;
        l_we    <= sel_we;
        l_uns   <= sel_uns;
        l_size  <= sel_size;
        l_addr  <= sel_addr[ADDR_W-1:0];
        l_wdata <= sel_wdata;
        l_err   <= sel_err;
      end
      if (state == ACCESS) begin
        if (l_err)
          rdata <= '0;
        else if (!l_we)
          rdata <= mem_rdata;
        if (!l_err) begin
          addr_hold  <= l_addr;
          wdata_hold <= l_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a little-endian
// byte-array memory model that sign/zero-extends loads from the size strobes.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, uns0, uns1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  size0, size1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata;
  logic        mem_we, mem_re, mem_b, mem_h, mem_w, mem_uns;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [7:0]  mem [0:4095];
  logic        clr_mem;
  logic [11:0] a;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.WIDTH(32), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .size0(size0), .size1(size1), .uns0(uns0), .uns1(uns1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_b(mem_b), .mem_h(mem_h), .mem_w(mem_w), .mem_uns(mem_uns),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_h || mem_w) mem[mem_addr + 12'd1] <= mem_wdata[15:8];
      if (mem_w) begin
        mem[mem_addr + 12'd2] <= mem_wdata[23:16];
        mem[mem_addr + 12'd3] <= mem_wdata[31:24];
      end
    end
  end

  always @* begin
    a = mem_addr;
    mem_rdata = 32'h0;
    if (mem_w)
      mem_rdata = {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
    else if (mem_h)
      mem_rdata = mem_uns ? {16'h0, mem[a + 12'd1], mem[a]}
                          : {{16{mem[a + 12'd1][7]}}, mem[a + 12'd1], mem[a]};
    else if (mem_b)
      mem_rdata = mem_uns ? {24'h0, mem[a]} : {{24{mem[a][7]}}, mem[a]};
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic we, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [1:0] sz, input logic un);
    if (k == 0) begin
      req0 = 1'b1; we0 = we; addr0 = ad; wdata0 = wd; size0 = sz; uns0 = un;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = ad; wdata1 = wd; size1 = sz; uns1 = un;
    end
  endtask

  task automatic clear_reqs();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Complete one uncontested access from IDLE, ending back in IDLE
  task automatic run_access(input int k, input logic we, input logic [31:0] ad,
                            input logic [31:0] wd, input logic [1:0] sz, input logic un);
    set_req(k, we, ad, wd, sz, un);
    tick();
    clear_reqs();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_mem = 1'b1;
    clear_reqs();
    tick();
    tick();
    set_req(0, 1'b1, 32'h10, 32'h1, 2'b10, 1'b0);
    #1;
    n_cmp++; if (gnt0 !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_gnt0: got %b want 0", gnt0); end
    n_cmp++; if ({done0, done1, err0, err1} !== 4'b0) begin n_bad++; $display("[TB] FAIL rst_done_err: got %b want 0000", {done0, done1, err0, err1}); end
    n_cmp++; if ({mem_we, mem_re, mem_b, mem_h, mem_w, mem_uns} !== 6'b0) begin n_bad++; $display("[TB] FAIL rst_strobes: got %b want 000000", {mem_we, mem_re, mem_b, mem_h, mem_w, mem_uns}); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_rdata: got %h want 00000000", rdata); end
    clear_reqs();
    rst = 1'b0;
    clr_mem = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
    #1;
    n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_bad++; $display("[TB] FAIL st_gnt: got gnt0=%b gnt1=%b want 1/0", gnt0, gnt1); end
    tick();
    clear_reqs();
    #1;
    n_cmp++; if ({mem_we, mem_re, mem_w} !== 3'b101) begin n_bad++; $display("[TB] FAIL st_strobes: got we/re/w=%b want 101", {mem_we, mem_re, mem_w}); end
    n_cmp++; if (mem_addr !== 12'h010) begin n_bad++; $display("[TB] FAIL st_addr: got %h want 010", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL st_wdata: got %h want deadbeef", mem_wdata); end
    n_cmp++; if (gnt0 !== 1'b0) begin n_bad++; $display("[TB] FAIL st_gnt_access: got %b want 0", gnt0); end
    tick();
    set_req(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    #1;
    n_cmp++; if ({done0, err0, done1} !== 3'b100) begin n_bad++; $display("[TB] FAIL st_done: got done0/err0/done1=%b want 100", {done0, err0, done1}); end
    n_cmp++; if (gnt0 !== 1'b1) begin n_bad++; $display("[TB] FAIL ld_gnt_in_done: got %b want 1", gnt0); end
    tick();
    clear_reqs();
    #1;
    n_cmp++; if ({mem_we, mem_re, mem_w} !== 3'b011) begin n_bad++; $display("[TB] FAIL ld_strobes: got we/re/w=%b want 011", {mem_we, mem_re, mem_w}); end
    tick();
    #1;
    n_cmp++; if (done0 !== 1'b1 || rdata !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL ld_rdata: got done0=%b rdata=%h want 1 deadbeef", done0, rdata); end
    tick();
  endtask

  task automatic test_round_robin();
    int exp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    set_req(1, 1'b0, 32'h14, 32'h0, 2'b10, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp = i % 2;
      n_cmp++; if (gnt0 !== (exp == 0) || gnt1 !== (exp == 1)) begin n_bad++; $display("[TB] FAIL rr_gnt%0d: got gnt0=%b gnt1=%b want owner %0d", i, gnt0, gnt1, exp); end
      if (i > 0) begin
        n_cmp++; if (done0 !== (exp == 1) || done1 !== (exp == 0)) begin n_bad++; $display("[TB] FAIL rr_done%0d: got done0=%b done1=%b want owner %0d", i, done0, done1, 1 - exp); end
      end
      tick();
      #1;
      n_cmp++; if ({gnt0, gnt1, done0, done1} !== 4'b0) begin n_bad++; $display("[TB] FAIL rr_access%0d: got gnt/done=%b want 0000", i, {gnt0, gnt1, done0, done1}); end
      tick();
      #1;
    end
    n_cmp++; if (done1 !== 1'b1 || done0 !== 1'b0) begin n_bad++; $display("[TB] FAIL rr_last_done: got done0=%b done1=%b want 0/1", done0, done1); end
    clear_reqs();
    tick();
  endtask

  task automatic test_errors();
    int          ek [3] = '{1, 0, 0};
    logic        ewe [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ead [3] = '{32'h21, 32'h1002, 32'h10};
    logic [1:0]  esz [3] = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      run_access(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
      n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL err%0d_pre_rdata: got %h want deadbeef", i, rdata); end
      set_req(ek[i], ewe[i], ead[i], 32'h12345678, esz[i], 1'b0);
      #1;
      n_cmp++; if ((ek[i] == 1 ? gnt1 : gnt0) !== 1'b1) begin n_bad++; $display("[TB] FAIL err%0d_gnt: got %b want 1", i, ek[i] == 1 ? gnt1 : gnt0); end
      tick();
      clear_reqs();
      #1;
      n_cmp++; if ({mem_we, mem_re, mem_b, mem_h, mem_w} !== 5'b0) begin n_bad++; $display("[TB] FAIL err%0d_strobes: got %b want 00000", i, {mem_we, mem_re, mem_b, mem_h, mem_w}); end
      tick();
      #1;
      n_cmp++; if ({done0, err0, done1, err1} !== (ek[i] == 1 ? 4'b0011 : 4'b1100)) begin n_bad++; $display("[TB] FAIL err%0d_resp: got done0/err0/done1/err1=%b for requester %0d", i, {done0, err0, done1, err1}, ek[i]); end
      n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("[TB] FAIL err%0d_rdata: got %h want 00000000", i, rdata); end
      tick();
    end
  endtask

  task automatic test_byte_sign();
    logic [31:0] exp_rd [2] = '{32'hFFFFFF80, 32'h00000080};
    set_req(0, 1'b1, 32'h7, 32'h00000080, 2'b00, 1'b0);
    tick();
    clear_reqs();
    #1;
    n_cmp++; if ({mem_we, mem_b, mem_h, mem_w} !== 4'b1100 || mem_addr !== 12'h007) begin n_bad++; $display("[TB] FAIL sb_strobes: got we/b/h/w=%b addr=%h want 1100 007", {mem_we, mem_b, mem_h, mem_w}, mem_addr); end
    tick();
    tick();
    for (int u = 0; u < 2; u++) begin
      set_req(0, 1'b0, 32'h7, 32'h0, 2'b00, u[0]);
      tick();
      clear_reqs();
      #1;
      n_cmp++; if ({mem_re, mem_b, mem_uns} !== {1'b1, 1'b1, u[0]}) begin n_bad++; $display("[TB] FAIL lb%0d_strobes: got re/b/uns=%b want 11%0d", u, {mem_re, mem_b, mem_uns}, u); end
      tick();
      #1;
      n_cmp++; if (done0 !== 1'b1 || rdata !== exp_rd[u]) begin n_bad++; $display("[TB] FAIL lb%0d_rdata: got done0=%b rdata=%h want 1 %h", u, done0, rdata, exp_rd[u]); end
      tick();
    end
  endtask

  task automatic test_reset_mid_access();
    set_req(0, 1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0);
    #1;
    n_cmp++; if (gnt0 !== 1'b1) begin n_bad++; $display("[TB] FAIL rma_gnt: got %b want 1", gnt0); end
    tick();
    clear_reqs();
    rst = 1'b1;
    #1;
    n_cmp++; if ({mem_we, mem_re, mem_w} !== 3'b0) begin n_bad++; $display("[TB] FAIL rma_strobes: got we/re/w=%b want 000", {mem_we, mem_re, mem_w}); end
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    set_req(1, 1'b0, 32'h24, 32'h0, 2'b10, 1'b0);
    #1;
    n_cmp++; if ({done0, done1} !== 2'b00) begin n_bad++; $display("[TB] FAIL rma_no_done: got done0/done1=%b want 00", {done0, done1}); end
    n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_bad++; $display("[TB] FAIL rma_prio: got gnt0=%b gnt1=%b want 1/0", gnt0, gnt1); end
    tick();
    clear_reqs();
    tick();
    #1;
    n_cmp++; if (done0 !== 1'b1 || rdata !== 32'h0) begin n_bad++; $display("[TB] FAIL rma_reload: got done0=%b rdata=%h want 1 00000000", done0, rdata); end
    tick();
  endtask

  task automatic test_fairness();
    set_req(1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin n_bad++; $display("[TB] FAIL fair_gnt1_%0d: got gnt0=%b gnt1=%b want 0/1", i, gnt0, gnt1); end
      if (i > 0) begin
        n_cmp++; if (done1 !== 1'b1) begin n_bad++; $display("[TB] FAIL fair_done1_%0d: got %b want 1", i, done1); end
      end
      tick();
      if (i == 2) set_req(0, 1'b0, 32'h14, 32'h0, 2'b10, 1'b0);
      #1;
      n_cmp++; if ({gnt0, gnt1} !== 2'b00) begin n_bad++; $display("[TB] FAIL fair_access%0d: got gnt0/gnt1=%b want 00", i, {gnt0, gnt1}); end
      tick();
      #1;
    end
    n_cmp++; if (done1 !== 1'b1 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_bad++; $display("[TB] FAIL fair_switch: got done1=%b gnt0=%b gnt1=%b want 1/1/0", done1, gnt0, gnt1); end
    tick();
    req0 = 1'b0;
    tick();
    #1;
    n_cmp++; if (done0 !== 1'b1 || gnt1 !== 1'b1) begin n_bad++; $display("[TB] FAIL fair_return: got done0=%b gnt1=%b want 1/1", done0, gnt1); end
    tick();
    clear_reqs();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_round_robin();
    test_errors();
    test_byte_sign();
    test_reset_mid_access();
    test_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Two-requester round-robin arbiter/sequencer for the single-port data memory.
- Requester 0 is the CPU core's load/store path; requester 1 is a loader/debug port that preloads or inspects data memory.
- Serialises accesses through a three-state FSM and drives the memory's size/sign strobes.
- Rejects out-of-range or misaligned accesses with an error response; rejected accesses never touch memory.

## Interface
Parameters:
- WIDTH, 32, data and requester address width
- ADDR_W, 12, memory address width (memory holds 2^ADDR_W bytes)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset is synchronous and active-high
- req0, req1  in  1  access request, requester 0 / 1
- we0, we1  in  1  1 = store, 0 = load
- addr0, addr1  in  WIDTH  byte address
- wdata0, wdata1  in  WIDTH  store data (low bytes used for byte/half)
- size0, size1  in  2  00 byte, 01 half, 10 word, 11 reserved
- uns0, uns1  in  1  zero-extend on load
- gnt0, gnt1  out  1  request accepted this cycle
- done0, done1  out  1  one-cycle completion pulse
- err0, err1  out  1  error flag, valid only with done
- rdata  out  WIDTH  load data, valid with done of the owning requester
- mem_we, mem_re  out  1  memory write / read strobes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_b, mem_h, mem_w, mem_uns  out  1  byte / half / word / unsigned-load selects
- mem_rdata  in  WIDTH  memory read data, combinational from mem_addr

## Operation
FSM states:
- IDLE: accept a request.
- ACCESS: drive memory for exactly one cycle.
- DONE: respond and optionally accept the next request.

Arbitration:
- Acceptance is legal in IDLE or DONE.
- If only one req is high, that requester wins.
- If both are high, the requester named by pointer prio wins. prio resets to 0.
- On a grant to k, prio becomes 1-k.
- gnt_k is combinational and high only in the accepting cycle.
- The requester holds req and all fields stable until gnt. After gnt it may drop req or present the next access.
- On acceptance, latch owner, we, addr, wdata, size and uns; go to ACCESS.
- Set the latched err flag at acceptance if any of these hold:
  - addr[WIDTH-1:ADDR_W] is nonzero;
  - size = 11;
  - size = 01 and addr[0] = 1;
  - size = 10 and addr[1:0] != 00.

ACCESS:
- If err = 0:
  - mem_we = we, mem_re = ~we;
  - mem_addr = addr[ADDR_W-1:0], mem_wdata = wdata;
  - mem_b / mem_h / mem_w decoded one-hot from size; mem_uns = uns.
  - For a load, capture mem_rdata into rdata at the end of the cycle.
- If err = 1: all mem strobes stay 0, rdata is loaded with 0.
- Always go to DONE.

DONE:
- done_owner = 1 and err_owner = latched err; the other requester's done/err stay 0.
- rdata holds the captured value until the next load completes. Stores leave rdata unchanged.
- If any req is high, arbitrate as in IDLE and go to ACCESS; otherwise go to IDLE.

Outside ACCESS:
- mem_we, mem_re, mem_b, mem_h, mem_w and mem_uns are 0.
- mem_addr and mem_wdata hold their last value.

Reset:
- State IDLE, prio 0, latched err 0, rdata 0.
- All gnt/done/err outputs and all mem strobes are 0 in any cycle where rst = 1, including mid-ACCESS. An in-flight store is dropped and no done is issued for it.

## Timing
- Latency is 2 cycles from the gnt edge to done: gnt in cycle T, ACCESS in T+1, done in T+2.
- Back-to-back requests give sustained throughput of one access per 2 cycles (grant in DONE).
- A granted requester is never granted again in the next acceptance slot while the other is requesting. This bounds the wait to one access of the other requester.
- gnt depends combinationally on req and state. There is no combinational path from mem_rdata to any output other than through the rdata register.
- The CPU stall is derived outside this block as req0 & ~done0.

## Test plan
- Reset, then req0 word store addr 0x10 wdata 0xDEADBEEF -> gnt0 at T, mem_we=1, mem_w=1, mem_addr=0x010 at T+1, done0=1, err0=0 at T+2. Then req0 word load 0x10 -> rdata=0xDEADBEEF with done0.
- req0 and req1 both held high for 4 accesses from reset -> grant order 0,1,0,1; each done on the owner only; a new gnt in every DONE cycle.
- Error cases, each -> done with err=1, no mem strobe, rdata=0:
  - req1 half load addr 0x21;
  - word store addr 0x1002 (out of range);
  - size=11.
- Store byte 0x80 at 0x7, then load byte signed (uns=0) then unsigned (uns=1) from 0x7 -> memory returns 0xFFFFFF80 and 0x00000080. Check mem_b=1 and mem_uns follow the request.
- rst asserted in the ACCESS cycle of a word store to 0x20 -> mem_we=0 that cycle, no done pulse, state IDLE, prio 0. A follow-up load of 0x20 returns the memory's reset content.
- req1 alone for 3 accesses, then req0 rises while req1 is still requesting -> req0 granted at the next acceptance slot.
